// File: rtl/mem_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// mem_arbiter_pkg
// Shared memory-handshake types plus the arbiter's own additions.
//   mem_input_t   : request  {Valid, Write, Addr, Mask, Wdata}
//   mem_output_t  : response {Ready, Rdata}
//   arb_state_t   : arbiter FSM encoding
//   MAX_ARB_PORTS : upper bound on requester count
//   wrap_idx()    : modulo-N pointer advance used by the round-robin scan
// -----------------------------------------------------------------------------
package mem_arbiter_pkg;

    localparam int MAX_ARB_PORTS = 8;

    typedef struct packed {
        logic        Valid;
        logic        Write;
        logic [31:0] Addr;
        logic [3:0]  Mask;
        logic [31:0] Wdata;
    } mem_input_t;

    typedef struct packed {
        logic        Ready;
        logic [31:0] Rdata;
    } mem_output_t;

    typedef enum logic [0:0] {
        ARB_IDLE = 1'b0,
        ARB_BUSY = 1'b1
    } arb_state_t;

    // (base + step) mod n, for walking a ring of n ports.
    function automatic int unsigned wrap_idx(input int unsigned base,
                                             input int unsigned step,
                                             input int unsigned n);
        return (base + step) % n;
    endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// -----------------------------------------------------------------------------
// mem_arbiter_if
// Bundles the requester side and the downstream side of the arbiter.
//   req_i   : per-port requests            (requesters -> arbiter)
//   resp_o  : per-port responses           (arbiter -> requesters)
//   mem_o   : downstream request           (arbiter -> cache/memory)
//   mem_i   : downstream response          (cache/memory -> arbiter)
//   grant_o : one-hot owner of the current transaction
//   busy_o  : transaction outstanding downstream
// Modports: slave = the arbiter, master = the surrounding system.
// -----------------------------------------------------------------------------
interface mem_arbiter_if
    import mem_arbiter_pkg::*;
#(
    parameter int NUM_PORTS = 2
);

    mem_input_t  [NUM_PORTS-1:0] req_i;
    mem_output_t [NUM_PORTS-1:0] resp_o;
    mem_input_t                  mem_o;
    mem_output_t                 mem_i;
    logic        [NUM_PORTS-1:0] grant_o;
    logic                        busy_o;

    modport slave (
        input  req_i,
        input  mem_i,
        output resp_o,
        output mem_o,
        output grant_o,
        output busy_o
    );

    modport master (
        output req_i,
        output mem_i,
        input  resp_o,
        input  mem_o,
        input  grant_o,
        input  busy_o
    );

endinterface

// File: rtl/mem_arbiter_rr_picker.sv
// -----------------------------------------------------------------------------
// rr_picker
// Combinational winner selection.
//   valid_i : request-valid vector, one bit per port
//   last_i  : index of the previous round-robin winner
//   mode_i  : 0 = round-robin starting after last_i, 1 = lowest index wins
//   found_o : at least one port is requesting
//   idx_o   : winning port index (meaningful only when found_o=1)
// -----------------------------------------------------------------------------
module rr_picker
    import mem_arbiter_pkg::*;
#(
    parameter int NUM_PORTS = 2,
    localparam int IDX_W    = $clog2(NUM_PORTS)
) (
    input  logic [NUM_PORTS-1:0] valid_i,
    input  logic [IDX_W-1:0]     last_i,
    input  logic                 mode_i,
    output logic                 found_o,
    output logic [IDX_W-1:0]     idx_o
);

    // Both scans run from the least to the most preferred candidate so the
    // final assignment that sticks is the best one.
    always_comb begin
        // NOTE: every output gets a default first; a path that leaves one
        // unassigned would infer a latch.
        found_o = 1'b0;
        idx_o   = '0;
        if (mode_i) begin
            for (int i = NUM_PORTS - 1; i >= 0; i--) begin
                if (valid_i[i]) begin
                    found_o = 1'b1;
                    idx_o   = IDX_W'(i);
                end
            end
        end else begin
            // Distance 1 from last_i is the most preferred, distance NUM_PORTS
            // (last_i itself) the least.
            for (int i = NUM_PORTS; i >= 1; i--) begin
                if (valid_i[wrap_idx(32'(last_i), i, NUM_PORTS)]) begin
                    found_o = 1'b1;
                    idx_o   = IDX_W'(wrap_idx(32'(last_i), i, NUM_PORTS));
                end
            end
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
// Arbitrates NUM_PORTS requesters onto one downstream cache/memory port.
//   clk_i : clock
//   rst_i : synchronous active-high reset
//   bus   : mem_arbiter_if.slave (req_i, resp_o, mem_o, mem_i, grant_o, busy_o)
// Parameters:
//   NUM_PORTS : requester count, 2..MAX_ARB_PORTS
//   PRIO_MODE : 0 = round-robin, 1 = fixed priority (port 0 highest)
// One request is latched per IDLE cycle and replayed downstream from a
// register until mem_i.Ready, so requesters cannot disturb it mid-flight.
// -----------------------------------------------------------------------------
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int NUM_PORTS = 2,
    parameter int PRIO_MODE = 0,
    localparam int IDX_W    = $clog2(NUM_PORTS)
) (
    input  logic          clk_i,
    input  logic          rst_i,
    mem_arbiter_if.slave  bus
);

    localparam logic [0:0] S_IDLE = ARB_IDLE;
    localparam logic [0:0] S_BUSY = ARB_BUSY;

    logic [0:0]           state_q;
    mem_input_t           req_q;
    logic [IDX_W-1:0]     gnt_q;
    logic [NUM_PORTS-1:0] grant_q;
    logic [IDX_W-1:0]     last_q;

    logic [NUM_PORTS-1:0] valid_vec;
    logic                 pick_found;
    logic [IDX_W-1:0]     pick_idx;
    mem_output_t [NUM_PORTS-1:0] resp;

    always_comb begin
        for (int p = 0; p < NUM_PORTS; p++) begin
            valid_vec[p] = bus.req_i[p].Valid;
        end
    end

    rr_picker #(.NUM_PORTS(NUM_PORTS)) u_picker (
        .valid_i (valid_vec),
        .last_i  (last_q),
        .mode_i  (PRIO_MODE != 0),
        .found_o (pick_found),
        .idx_o   (pick_idx)
    );

    // NOTE: all state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            // NOTE: req_q is a datapath register but it drives mem_o
            // directly, so it must be cleared on reset, not left undefined.
            req_q   <= '0;
            gnt_q   <= '0;
            grant_q <= '0;
            last_q  <= IDX_W'(NUM_PORTS - 1);
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (pick_found) begin
                        req_q       <= bus.req_i[pick_idx];
                        req_q.Valid <= 1'b1;
                        gnt_q       <= pick_idx;
                        grant_q     <= {{(NUM_PORTS-1){1'b0}}, 1'b1} << pick_idx;
                        if (PRIO_MODE == 0) begin
                            last_q <= pick_idx;
                        end
                        state_q <= S_BUSY;
                    end
                end
                default: begin
                    // Clearing req_q here drops mem_o.Valid for the IDLE
                    // cycle that separates back-to-back transactions.
                    if (bus.mem_i.Ready) begin
                        req_q   <= '0;
                        grant_q <= '0;
                        state_q <= S_IDLE;
                    end
                end
            endcase
        end
    end

    // Only the owner sees Ready/Rdata; a Ready arriving while IDLE is dropped.
    always_comb begin
        resp = '0;
        if (state_q == S_BUSY && bus.mem_i.Ready) begin
            resp[gnt_q].Ready = 1'b1;
            resp[gnt_q].Rdata = bus.mem_i.Rdata;
        end
    end

    assign bus.resp_o  = resp;
    assign bus.mem_o   = req_q;
    assign bus.grant_o = grant_q;
    assign bus.busy_o  = (state_q == S_BUSY);

endmodule

// File: tb/tb_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_arbiter
// Three arbiter instances sharing clock and reset:
//   dut_a : 2 ports, round-robin  (single read, write, spurious Ready,
//           dropped Valid, reset mid-transaction)
//   dut_b : 3 ports, round-robin  (fairness over 9 transactions)
//   dut_p : 2 ports, fixed priority
// -----------------------------------------------------------------------------
module tb_mem_arbiter;
    import mem_arbiter_pkg::*;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    mem_arbiter_if #(.NUM_PORTS(2)) if_a ();
    mem_arbiter_if #(.NUM_PORTS(3)) if_b ();
    mem_arbiter_if #(.NUM_PORTS(2)) if_p ();

    mem_arbiter #(.NUM_PORTS(2), .PRIO_MODE(0)) dut_a (
        .clk_i (clk), .rst_i (rst), .bus (if_a.slave)
    );
    mem_arbiter #(.NUM_PORTS(3), .PRIO_MODE(0)) dut_b (
        .clk_i (clk), .rst_i (rst), .bus (if_b.slave)
    );
    mem_arbiter #(.NUM_PORTS(2), .PRIO_MODE(1)) dut_p (
        .clk_i (clk), .rst_i (rst), .bus (if_p.slave)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [127:0] got,
                         input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic mem_input_t mk_req(input logic w, input logic [31:0] a,
                                          input logic [3:0] m,
                                          input logic [31:0] d);
        return '{Valid: 1'b1, Write: w, Addr: a, Mask: m, Wdata: d};
    endfunction

    mem_input_t exp_w;
    logic [2:0] exp_g3;

    initial begin
        rst       = 1'b1;
        if_a.req_i = '0; if_a.mem_i = '0;
        if_b.req_i = '0; if_b.mem_i = '0;
        if_p.req_i = '0; if_p.mem_i = '0;
        step();
        step();

        // ---------------- reset state ----------------
        check("rst_mem_o",  if_a.mem_o,   '0);
        check("rst_grant",  if_a.grant_o, '0);
        check("rst_busy",   if_a.busy_o,  '0);
        check("rst_resp",   if_a.resp_o,  '0);
        check("rst_busy_b", if_b.busy_o,  '0);
        rst = 1'b0;

        // ---------------- single read on port 1 ----------------
        if_a.req_i[1] = mk_req(1'b0, 32'h100, 4'hF, 32'h0);
        #1;
        check("rd_not_comb", if_a.mem_o.Valid, 1'b0);
        step();
        check("rd_valid",  if_a.mem_o.Valid, 1'b1);
        check("rd_addr",   if_a.mem_o.Addr,  32'h100);
        check("rd_write",  if_a.mem_o.Write, 1'b0);
        check("rd_grant",  if_a.grant_o,     2'b10);
        check("rd_busy",   if_a.busy_o,      1'b1);
        step();
        step();
        check("rd_wait_rdy", if_a.resp_o[1].Ready, 1'b0);
        step();
        if_a.mem_i = '{Ready: 1'b1, Rdata: 32'hDEADBEEF};
        #1;
        check("rd_ready",  if_a.resp_o[1].Ready, 1'b1);
        check("rd_rdata",  if_a.resp_o[1].Rdata, 32'hDEADBEEF);
        check("rd_other",  if_a.resp_o[0],       '0);
        step();
        if_a.mem_i    = '0;
        if_a.req_i[1] = '0;
        #1;
        check("rd_done_busy",  if_a.busy_o,      1'b0);
        check("rd_done_grant", if_a.grant_o,     2'b00);
        check("rd_done_valid", if_a.mem_o.Valid, 1'b0);

        // ---------------- spurious Ready while IDLE ----------------
        if_a.mem_i = '{Ready: 1'b1, Rdata: 32'h5555_5555};
        #1;
        check("spur_resp", if_a.resp_o, '0);
        step();
        check("spur_busy", if_a.busy_o, 1'b0);
        if_a.mem_i = '0;

        // ---------------- write passthrough + dropped Valid ----------------
        exp_w = mk_req(1'b1, 32'h20, 4'b0011, 32'h0000ABCD);
        if_a.req_i[0] = exp_w;
        step();
        check("wr_mem_o",  if_a.mem_o,   exp_w);
        check("wr_grant",  if_a.grant_o, 2'b01);
        if_a.req_i[0] = '{Valid: 1'b0, Write: 1'b0, Addr: 32'hFFFF,
                          Mask: 4'h0, Wdata: 32'h0};
        step();
        check("drop_mem_o", if_a.mem_o,  exp_w);
        check("drop_busy",  if_a.busy_o, 1'b1);
        if_a.mem_i = '{Ready: 1'b1, Rdata: 32'h1234};
        #1;
        check("drop_ready", if_a.resp_o[0].Ready, 1'b1);
        check("drop_rdata", if_a.resp_o[0].Rdata, 32'h1234);
        check("drop_other", if_a.resp_o[1].Ready, 1'b0);
        step();
        if_a.mem_i = '0;

        // ---------------- reset mid-transaction ----------------
        // Port 0 won last, so port 1 wins the next round-robin pick.
        if_a.req_i[1] = mk_req(1'b0, 32'h300, 4'hF, 32'h0);
        step();
        check("rm_grant_pre", if_a.grant_o, 2'b10);
        rst = 1'b1;
        step();
        rst = 1'b0;
        if_a.req_i[0] = mk_req(1'b0, 32'h400, 4'hF, 32'h0);
        #1;
        check("rm_valid", if_a.mem_o.Valid, 1'b0);
        check("rm_busy",  if_a.busy_o,      1'b0);
        check("rm_grant", if_a.grant_o,     2'b00);
        step();
        check("rm_first_grant", if_a.grant_o,    2'b01);
        check("rm_first_addr",  if_a.mem_o.Addr, 32'h400);
        if_a.mem_i = '{Ready: 1'b1, Rdata: 32'h0};
        step();
        if_a.mem_i = '0;
        if_a.req_i = '0;

        // ---------------- round-robin fairness, 3 ports ----------------
        for (int p = 0; p < 3; p++) begin
            if_b.req_i[p] = mk_req(1'b0, 32'h1000 + 32'(p) * 32'h10, 4'hF, 32'h0);
        end
        for (int k = 0; k < 9; k++) begin
            step();
            exp_g3 = 3'b001 << (k % 3);
            check("rr_grant", if_b.grant_o,    exp_g3);
            check("rr_addr",  if_b.mem_o.Addr, 32'h1000 + 32'(k % 3) * 32'h10);
            if_b.mem_i = '{Ready: 1'b1, Rdata: 32'hA000 + 32'(k)};
            #1;
            check("rr_rdata", if_b.resp_o[k % 3].Rdata, 32'hA000 + 32'(k));
            step();
            if_b.mem_i = '0;
        end
        if_b.req_i = '0;

        // ---------------- fixed priority ----------------
        if_p.req_i[0] = mk_req(1'b0, 32'h500, 4'hF, 32'h0);
        if_p.req_i[1] = mk_req(1'b0, 32'h600, 4'hF, 32'h0);
        for (int k = 0; k < 3; k++) begin
            step();
            check("fp_grant0", if_p.grant_o, 2'b01);
            if_p.mem_i = '{Ready: 1'b1, Rdata: 32'h0};
            if (k == 2) if_p.req_i[0].Valid = 1'b0;
            step();
            if_p.mem_i = '0;
        end
        step();
        check("fp_grant1", if_p.grant_o,    2'b10);
        check("fp_addr1",  if_p.mem_o.Addr, 32'h600);
        if_p.mem_i = '{Ready: 1'b1, Rdata: 32'h77};
        #1;
        check("fp_rdata1", if_p.resp_o[1].Rdata, 32'h77);
        step();
        if_p.mem_i = '0;
        if_p.req_i = '0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Multi-requester front end for the shared memory subsystem.
- Arbitrates NUM_PORTS requesters onto one downstream port: the cache, or the main memory when uncached. Example requesters: instruction fetch, load/store, debug/DMA.
- All sides use the mem_pkg handshake: mem_input_t {Valid, Write, Addr, Mask, Wdata} and mem_output_t {Ready, Rdata}.
- Sits between the requesters' LoadStoreUnit outputs and the cache's cache_i input.

Parameters:
- NUM_PORTS, 2, number of requesters; legal range 2..8.
- PRIO_MODE, 0, arbitration mode: 0 = round-robin, 1 = fixed priority (port 0 highest).

Ports:
- clk_i  input  1  clock.
- rst_i  input  1  synchronous, active-high reset.
- req_i  input  mem_input_t[NUM_PORTS]  per-port requests.
- resp_o  output  mem_output_t[NUM_PORTS]  per-port responses.
- mem_o  output  mem_input_t  request to the downstream cache or memory.
- mem_i  input  mem_output_t  response from downstream.
- grant_o  output  NUM_PORTS  one-hot; identifies the port owning the current transaction.
- busy_o  output  1  high while a transaction is outstanding downstream.

Behaviour:
- Reset is synchronous and active-high; there is one clock, clk_i. All state updates on the rising edge of clk_i.
- Requester protocol:
  - A requester raises Valid and holds Valid/Write/Addr/Mask/Wdata stable until it sees Ready=1.
  - Ready is a 1-cycle pulse, with Rdata valid in that cycle.
  - Valid may remain high in the Ready cycle for a back-to-back request.
- Reset values:
  - State = IDLE; mem_o all-zero (Valid=0); resp_o[*].Ready=0; resp_o[*].Rdata=0; grant_o=0; busy_o=0.
  - Round-robin pointer last_q = NUM_PORTS-1, so port 0 wins first.
- FSM, 2 states (arb_state_t):
  - IDLE:
    - If no req_i[*].Valid: stay in IDLE.
    - Otherwise select a winner:
      - RR mode: first Valid port scanning last_q+1, last_q+2, … modulo NUM_PORTS.
      - Fixed mode: lowest-index Valid port.
    - On the edge: latch the winner's request fields into req_q, set gnt_q (index) and grant_o (one-hot), update last_q to the winner (RR only), go to BUSY.
  - BUSY:
    - mem_o = req_q with Valid=1; busy_o=1.
    - mem_o is registered; it is never combinational from req_i.
    - When mem_i.Ready=1:
      - resp_o[gnt_q].Ready=1 and resp_o[gnt_q].Rdata=mem_i.Rdata, combinational in the same cycle.
      - Go to IDLE; grant_o clears on that edge.
- Non-granted ports:
  - Ready=0 always.
  - Rdata=0.
- Latency:
  - Valid seen in IDLE → mem_o.Valid the next cycle.
  - Minimum total latency = 1 + downstream latency.
  - There is one IDLE cycle between transactions, guaranteeing mem_o.Valid drops for ≥1 cycle so the cache sees distinct requests.
- Boundary and error conditions:
  - Simultaneous requests: exactly one winner per IDLE cycle. In RR mode, with all ports continuously Valid, every port is served once per NUM_PORTS transactions; starvation is impossible.
  - Granted requester drops Valid mid-transaction (protocol violation): the transaction completes from req_q and Ready is still pulsed to that port.
  - mem_i.Ready while in IDLE: ignored; no resp_o Ready is generated.
  - Reset asserted mid-transaction: return to the reset values on the next edge, discarding the outstanding transaction. The downstream block shares rst_i.
  - last_q wraps from NUM_PORTS-1 to 0.
  - PRIO_MODE=1: last_q is held at its reset value.

Decomposition:
- mem_pkg additions:
  - typedef enum arb_state_t {ARB_IDLE, ARB_BUSY}.
  - Constant MAX_ARB_PORTS = 8.
- mem_input_t and mem_output_t are reused unchanged.
- Sub-module rr_picker (combinational):
  - Inputs: valid vector, last pointer, mode.
  - Outputs: found flag, winner index.
  - Unit-testable in isolation.
- mem_arbiter holds the FSM, the request register and the response routing.

Test Plan:
- Single request: NUM_PORTS=2; port 1 read of Addr 0x100; downstream returns Ready after 3 cycles with Rdata 0xDEADBEEF → mem_o.Valid rises 1 cycle after req; resp_o[1].Ready pulses once with 0xDEADBEEF; resp_o[0].Ready stays 0; grant_o=2'b10 during BUSY.
- RR fairness: NUM_PORTS=3, all ports continuously Valid for 9 transactions after reset → grant order 0,1,2,0,1,2,0,1,2.
- Fixed priority: PRIO_MODE=1, ports 0 and 1 continuously Valid → port 0 served every transaction; port 1 is served only after port 0 drops Valid.
- Write passthrough: port 0 writes Addr 0x20, Mask 4'b0011, Wdata 0x0000ABCD → mem_o carries Write=1 with identical fields; resp_o[0].Ready pulses on mem_i.Ready.
- Reset mid-op: rst_i asserted 1 cycle while in BUSY → next cycle mem_o.Valid=0, busy_o=0, grant_o=0; the next request is granted to port 0 first.
- Spurious and violating inputs:
  - mem_i.Ready=1 while IDLE → no resp_o Ready.
  - Granted port drops Valid in BUSY → mem_o unchanged; that port still receives its Ready pulse.
